infix_to_postfix: RTL and testbench
===================================

# infix_to_postfix

Upstream token converter for the postfix evaluator. It accepts an infix expression as a contiguous token burst, buffers it, and converts it to postfix order with an operator stack (shunting-yard). It then replays the result as one gap-free burst on `OUT_VALID`/`OUT`/`OUT_MODE`, which connect directly to the evaluator's `IN_VALID`/`IN`/`OP_MODE`.

## Interface
- `DEPTH`, 16: token capacity of the input buffer and of the output buffer.
- `STK_DEPTH`, 8: operator stack capacity.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `IN_VALID`  in  1  high for each cycle that carries an infix token; one expression is one contiguous high burst.
- `IN`  in  4  token value; an operand `0..15` when `IN_MODE=0`.
- `IN_MODE`  in  1  0 = operand, 1 = operator. Operator codes: `0001` +, `0010` -, `0100` *, `1000` (, `1001` ).
- `OUT_VALID`  out  1  high for each postfix token, contiguous burst.
- `OUT`  out  4  postfix token value.
- `OUT_MODE`  out  1  0 = operand, 1 = operator; only + - * ever emitted.
- `BUSY`  out  1  high in CONV/FLUSH/EMIT; input ignored while high.
- `ERR`  out  1  sticky error flag, cleared at the start of the next LOAD.

## Operation
- States:
  - **IDLE:** entered at reset.
  - **LOAD:** entered when `IN_VALID=1` is sampled in IDLE. That token is stored at `in_buf[0]`, `wr=1`, and `ERR` is cleared.
    - Each further `IN_VALID=1` cycle stores `{IN_MODE,IN}` at `in_buf[wr]` and increments `wr`.
    - If `wr==DEPTH`, the token is dropped and `ERR=1`.
    - The first `IN_VALID=0` sample moves to CONV with `rd=0`.
  - **CONV:** exactly one action per cycle, on `tok=in_buf[rd]`:
    - `rd==wr`: go to FLUSH, no other action.
    - Operand: append to `out_buf`, `rd++`.
    - `(`: push, `rd++`.
    - `)`, stack top is an operator: pop it to `out_buf`; `rd` holds.
    - `)`, stack top is `(`: pop and discard, `rd++`.
    - `)`, stack empty: `ERR=1`, `rd++`.
    - `+ - *`, top is an operator with precedence >= tok (`*`=2, `+ -`=1): pop it to `out_buf`; `rd` holds. This gives left associativity.
    - `+ - *`, otherwise: push, `rd++`.
    - Undefined operator code: `ERR=1`, `rd++`.
    - Push with the stack full: `ERR=1`, token discarded.
  - **FLUSH:** pops one stack entry per cycle.
    - Operators are appended to `out_buf`; a leftover `(` is discarded and sets `ERR=1`.
    - When the stack is empty, go to EMIT with `oc=0`.
  - **EMIT:** drives `out_buf[oc]` with `OUT_VALID=1` and `oc++` each cycle until `oc==out_cnt`, then goes to IDLE.
    - `OUT_VALID` drops to 0 the cycle after the last token.
    - If `out_cnt==0`, go straight to IDLE with no burst.
- `out_buf` cannot overflow: its length is at most `wr`.
- Reset, at any time, including mid-EMIT: state IDLE; `wr`, `rd`, stack pointer, `out_cnt`, `oc` = 0; all outputs 0. A truncated burst is acceptable; the downstream evaluator shares `RESET`.

## Timing
- Outputs are registered.
- `BUSY` is high from the edge that enters CONV until the edge that returns to IDLE.
- CONV latency is one cycle per CONV action plus 1 for the FLUSH transition. FLUSH costs one cycle per stack entry plus 1. The first `OUT_VALID` comes one cycle after entering EMIT.
- A new expression may start the cycle after `BUSY` falls.
- `IN_VALID` high while `BUSY=1` is ignored and does not set `ERR`.
- The EMIT burst always carries exactly `out_cnt` consecutive `OUT_VALID=1` cycles.

## Test plan
- Precedence: `3 + 4 * 2` → burst `3 4 2 * +`, with `OUT_MODE` `0 0 0 1 1`, 5 cycles, `ERR=0`.
- Parentheses: `( 1 + 2 ) * 3` → `1 2 + 3 *`; burst length 5.
- Left associativity: `5 - 3 - 1` → `5 3 - 1 -`; and `2 * 3 * 4` → `2 3 * 4 *`.
- Malformed input: `( 1 + 2` → `1 2 +` with `ERR=1`; `1 ) + 2` → `1 2 +` with `ERR=1`.
- Overflow and busy handling: a 17-token burst keeps the first 16 and sets `ERR=1`. `IN_VALID` pulses during `BUSY` change nothing.
- Reset: drop `RESET` mid-CONV and mid-EMIT → `OUT_VALID`, `OUT`, `OUT_MODE`, `BUSY`, `ERR` are 0 immediately. The next expression `7 + 1` → `7 1 +`.

Source files
------------

// File: rtl/infix_to_postfix_if.sv
// ============================================================================
// infix_to_postfix_if : token-in / postfix-out bus of the infix converter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface infix_to_postfix_if;
    logic       IN_VALID;
    logic [3:0] IN;
    logic       IN_MODE;
    logic       OUT_VALID;
    logic [3:0] OUT;
    logic       OUT_MODE;
    logic       BUSY;
    logic       ERR;

    modport master (
        output IN_VALID, IN, IN_MODE,
        input  OUT_VALID, OUT, OUT_MODE, BUSY, ERR
    );

    modport slave (
        input  IN_VALID, IN, IN_MODE,
        output OUT_VALID, OUT, OUT_MODE, BUSY, ERR
    );
endinterface

`default_nettype wire

// File: rtl/infix_to_postfix.sv
// ============================================================================
// infix_to_postfix : buffers an infix token burst, converts it with a
// shunting-yard operator stack and replays the postfix result as one burst.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module infix_to_postfix #(
    parameter int DEPTH     = 16,
    parameter int STK_DEPTH = 8
) (
    input wire                 CLK,
    input wire                 RESET,
    infix_to_postfix_if.slave  bus
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = $clog2(DEPTH);
    localparam int SW  = $clog2(STK_DEPTH + 1);
    localparam int SIW = $clog2(STK_DEPTH);

    localparam logic [3:0] C_ADD = 4'b0001;
    localparam logic [3:0] C_SUB = 4'b0010;
    localparam logic [3:0] C_MUL = 4'b0100;
    localparam logic [3:0] C_LP  = 4'b1000;
    localparam logic [3:0] C_RP  = 4'b1001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CONV  = 3'd2,
        S_FLUSH = 3'd3,
        S_EMIT  = 3'd4
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_in_buf  [0:DEPTH-1];
    logic [4:0]      r_out_buf [0:DEPTH-1];
    logic [3:0]      r_stack   [0:STK_DEPTH-1];
    logic [CW-1:0]   r_wr, r_rd, r_out_cnt, r_oc;
    logic [SW-1:0]   r_sp;
    logic            r_out_valid, r_out_mode, r_busy, r_err;
    logic [3:0]      r_out;

    logic [4:0]      w_tok, w_app_tok;
    logic [3:0]      w_top;
    logic            w_stk_empty, w_stk_full, w_top_is_op;
    logic            w_push, w_pop, w_app, w_rd_inc, w_err_set, w_err_clr;
    logic            w_emit, w_ld_first, w_ld_next, w_buf_wr;
    logic [IW-1:0]   w_buf_idx;

    function automatic logic [1:0] f_prec(input logic [3:0] c);
        if (c == C_MUL)                   return 2'd2;
        else if (c == C_ADD || c == C_SUB) return 2'd1;
        else                              return 2'd0;
    endfunction

    assign w_tok       = r_in_buf[r_rd[IW-1:0]];
    assign w_top       = r_stack[SIW'(r_sp - 1'b1)];
    assign w_stk_empty = (r_sp == '0);
    assign w_stk_full  = (r_sp == SW'(STK_DEPTH));
    assign w_top_is_op = !w_stk_empty && (w_top != C_LP);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_app       = 1'b0;
        w_app_tok   = '0;
        w_rd_inc    = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_emit      = 1'b0;
        w_ld_first  = 1'b0;
        w_ld_next   = 1'b0;
        w_buf_wr    = 1'b0;
        w_buf_idx   = '0;
        case (r_state)
            S_IDLE: if (bus.IN_VALID) begin
                w_state_nxt = S_LOAD;
                w_ld_first  = 1'b1;
                w_err_clr   = 1'b1;
                w_buf_wr    = 1'b1;
            end
            S_LOAD: begin
                if (!bus.IN_VALID) begin
                    w_state_nxt = S_CONV;
                end else if (r_wr == CW'(DEPTH)) begin
                    w_err_set = 1'b1;
                end else begin
                    w_ld_next = 1'b1;
                    w_buf_wr  = 1'b1;
                    w_buf_idx = r_wr[IW-1:0];
                end
            end
            S_CONV: begin
                if (r_rd == r_wr) begin
                    w_state_nxt = S_FLUSH;
                end else if (!w_tok[4]) begin
                    w_app     = 1'b1;
                    w_app_tok = w_tok;
                    w_rd_inc  = 1'b1;
                end else begin
                    case (w_tok[3:0])
                        C_LP: begin
                            w_rd_inc = 1'b1;
                            if (w_stk_full) w_err_set = 1'b1;
                            else            w_push    = 1'b1;
                        end
                        C_RP: begin
                            if (w_stk_empty) begin
                                w_err_set = 1'b1;
                                w_rd_inc  = 1'b1;
                            end else if (w_top == C_LP) begin
                                w_pop    = 1'b1;
                                w_rd_inc = 1'b1;
                            end else begin
                                w_pop     = 1'b1;
                                w_app     = 1'b1;
                                w_app_tok = {1'b1, w_top};
                            end
                        end
                        C_ADD, C_SUB, C_MUL: begin
                            // Popping on equal precedence yields left associativity
                            if (w_top_is_op && f_prec(w_top) >= f_prec(w_tok[3:0])) begin
                                w_pop     = 1'b1;
                                w_app     = 1'b1;
                                w_app_tok = {1'b1, w_top};
                            end else begin
                                w_rd_inc = 1'b1;
                                if (w_stk_full) w_err_set = 1'b1;
                                else            w_push    = 1'b1;
                            end
                        end
                        default: begin
                            w_err_set = 1'b1;
                            w_rd_inc  = 1'b1;
                        end
                    endcase
                end
            end
            S_FLUSH: begin
                if (w_stk_empty) begin
                    w_state_nxt = S_EMIT;
                end else begin
                    w_pop = 1'b1;
                    if (w_top == C_LP) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_app     = 1'b1;
                        w_app_tok = {1'b1, w_top};
                    end
                end
            end
            S_EMIT: begin
                if (r_oc == r_out_cnt) w_state_nxt = S_IDLE;
                else                   w_emit      = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_sp        <= '0;
            r_out_cnt   <= '0;
            r_oc        <= '0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_mode  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_mode  <= 1'b0;
            r_busy      <= (w_state_nxt == S_CONV) || (w_state_nxt == S_FLUSH) ||
                           (w_state_nxt == S_EMIT);
            if (w_ld_first) begin
                r_wr      <= CW'(1);
                r_rd      <= '0;
                r_sp      <= '0;
                r_out_cnt <= '0;
                r_oc      <= '0;
            end
            if (w_ld_next) r_wr <= r_wr + 1'b1;
            if (w_err_clr) r_err <= 1'b0;
            if (w_err_set) r_err <= 1'b1;
            if (w_push)    r_sp <= r_sp + 1'b1;
            if (w_pop)     r_sp <= r_sp - 1'b1;
            if (w_app)     r_out_cnt <= r_out_cnt + 1'b1;
            if (w_rd_inc)  r_rd <= r_rd + 1'b1;
            if (w_emit) begin
                r_out_valid <= 1'b1;
                {r_out_mode, r_out} <= r_out_buf[r_oc[IW-1:0]];
                r_oc        <= r_oc + 1'b1;
            end
        end
    end

    // Storage arrays carry no reset; their contents are qualified by the counters
    always_ff @(posedge CLK) begin
        if (w_buf_wr) r_in_buf[w_buf_idx]            <= {bus.IN_MODE, bus.IN};
        if (w_push)   r_stack[r_sp[SIW-1:0]]         <= w_tok[3:0];
        if (w_app)    r_out_buf[r_out_cnt[IW-1:0]]   <= w_app_tok;
    end

    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT       = r_out;
    assign bus.OUT_MODE  = r_out_mode;
    assign bus.BUSY      = r_busy;
    assign bus.ERR       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_infix_to_postfix.sv
// ============================================================================
// tb_infix_to_postfix : directed vector bench for the infix-to-postfix converter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_infix_to_postfix;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    infix_to_postfix_if bus();

    infix_to_postfix #(.DEPTH(16), .STK_DEPTH(8)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    typedef struct packed {
        logic [159:0] expr;
        logic [159:0] post;
        logic         err;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [0:NV-1];

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] in_tok  [0:19];
    logic [4:0] exp_tok [0:19];
    logic [4:0] act_tok [0:19];
    int in_n, exp_n, act_n;

    function automatic logic [4:0] ch2tok(input logic [7:0] c);
        case (c)
            "+":     return 5'h11;
            "-":     return 5'h12;
            "*":     return 5'h14;
            "(":     return 5'h18;
            ")":     return 5'h19;
            "?":     return 5'h13;
            default: return {1'b0, 4'(c - 8'h30)};
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic chk_zero(input string name);
        check({name, " OUT_VALID"}, int'(bus.OUT_VALID), 0);
        check({name, " OUT"},       int'(bus.OUT),       0);
        check({name, " OUT_MODE"},  int'(bus.OUT_MODE),  0);
        check({name, " BUSY"},      int'(bus.BUSY),      0);
        check({name, " ERR"},       int'(bus.ERR),       0);
    endtask

    task automatic drive(input logic [159:0] expr);
        in_n = 0;
        for (int i = 19; i >= 0; i--)
            if (expr[i*8 +: 8] != 8'h00) begin
                in_tok[in_n] = ch2tok(expr[i*8 +: 8]);
                in_n++;
            end
        for (int i = 0; i < in_n; i++) begin
            @(negedge CLK);
            bus.IN_VALID = 1'b1;
            bus.IN       = in_tok[i][3:0];
            bus.IN_MODE  = in_tok[i][4];
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        bus.IN       = 4'h0;
        bus.IN_MODE  = 1'b0;
    endtask

    task automatic run(input logic [159:0] expr, input logic [159:0] post,
                       input logic exp_err, input bit poke, input string name,
                       output int busy_cycles);
        bit seen_busy, ended, started, stopped, gap;
        int bad;
        exp_n = 0;
        for (int i = 19; i >= 0; i--)
            if (post[i*8 +: 8] != 8'h00) begin
                exp_tok[exp_n] = ch2tok(post[i*8 +: 8]);
                exp_n++;
            end
        drive(expr);
        act_n = 0; busy_cycles = 0;
        seen_busy = 0; ended = 0; started = 0; stopped = 0; gap = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (bus.OUT_VALID) begin
                if (stopped) gap = 1;
                started = 1;
                if (act_n < 20) act_tok[act_n] = {bus.OUT_MODE, bus.OUT};
                act_n++;
            end else if (started) begin
                stopped = 1;
            end
            if (bus.BUSY) begin
                seen_busy = 1;
                busy_cycles++;
            end
            if (poke) begin
                bus.IN_VALID = bus.BUSY;
                bus.IN       = 4'($urandom_range(0, 15));
                bus.IN_MODE  = 1'($urandom_range(0, 1));
            end
            if (seen_busy && !bus.BUSY) begin
                ended = 1;
                break;
            end
        end
        bus.IN_VALID = 1'b0;
        check({name, " done"}, int'(ended), 1);
        check({name, " len"}, act_n, exp_n);
        n_checks++;
        bad = -1;
        for (int i = 0; i < exp_n && i < act_n && i < 20; i++)
            if (bad < 0 && act_tok[i] !== exp_tok[i]) bad = i;
        if (bad < 0) n_pass++;
        else $display("FAIL %s seq: token %0d got %h, expected %h",
                      name, bad, act_tok[bad], exp_tok[bad]);
        check({name, " gap"}, int'(gap), 0);
        check({name, " err"}, int'(bus.ERR), int'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bc;
        bit got;
        vecs[0]  = '{expr: "3+4*2",             post: "342*+",            err: 1'b0};
        vecs[1]  = '{expr: "(1+2)*3",           post: "12+3*",            err: 1'b0};
        vecs[2]  = '{expr: "5-3-1",             post: "53-1-",            err: 1'b0};
        vecs[3]  = '{expr: "2*3*4",             post: "23*4*",            err: 1'b0};
        vecs[4]  = '{expr: "(1+2",              post: "12+",              err: 1'b1};
        vecs[5]  = '{expr: "1)+2",              post: "12+",              err: 1'b1};
        vecs[6]  = '{expr: "1+2*(3-4)",         post: "1234-*+",          err: 1'b0};
        vecs[7]  = '{expr: "9",                 post: "9",                err: 1'b0};
        vecs[8]  = '{expr: "()",                post: "",                 err: 1'b0};
        vecs[9]  = '{expr: "1?2",               post: "12",               err: 1'b1};
        vecs[10] = '{expr: "(((((((((1",        post: "1",                err: 1'b1};
        vecs[11] = '{expr: "1+1+1+1+1+1+1+1+1", post: "11+1+1+1+1+1+1++", err: 1'b1};

        RESET = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.IN       = 4'h0;
        bus.IN_MODE  = 1'b0;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        RESET = 1'b1;
        @(negedge CLK);

        for (int v = 0; v < NV; v++) begin
            run(vecs[v].expr, vecs[v].post, vecs[v].err, 1'b0, $sformatf("vec%0d", v), bc);
            if (v == 0) check("vec0 busy cycles", bc, 15);
            @(negedge CLK);
        end

        run("3+4*2", "342*+", 1'b0, 1'b1, "busy_poke", bc);
        @(negedge CLK);

        // Reset while converting, with ERR already raised by a stray ')'
        drive(")1+2+3");
        @(negedge CLK);
        @(negedge CLK);
        check("midconv BUSY", int'(bus.BUSY), 1);
        check("midconv ERR", int'(bus.ERR), 1);
        RESET = 1'b0;
        #1;
        chk_zero("midconv reset");
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Reset in the middle of the output burst
        drive("(1+2");
        got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (bus.OUT_VALID) begin
                got = 1;
                break;
            end
        end
        check("midemit burst seen", int'(got), 1);
        check("midemit ERR", int'(bus.ERR), 1);
        RESET = 1'b0;
        #1;
        chk_zero("midemit reset");
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        run("7+1", "71+", 1'b0, 1'b0, "after_reset", bc);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
